// File: rtl/fb_tap_sequencer.sv
// TAPS-deep signed sample delay line with a decimation phase counter.
// Every DECIM-th accepted sample starts a serial sweep of the line, tap 0 first.
module fb_tap_sequencer #(
  parameter int DATA_W = 13,
  parameter int TAPS   = 119,
  parameter int DECIM  = 60,
  parameter int IDX_W  = $clog2(TAPS),
  parameter int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] filter_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] tap_data,
  output logic [IDX_W-1:0]         tap_idx,
  output logic                     tap_valid,
  input  logic                     tap_ready,
  output logic                     tap_last,
  output logic                     frame_start,
  output logic [PH_W-1:0]          phase,
  output logic                     busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);

  state_t                   state;
  state_t                   state_next;
  logic signed [DATA_W-1:0] line [TAPS];
  logic                     accept;
  logic                     transfer;

  // flush overrides everything; accept and transfer are already gated by it
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    tap_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && clk_enable && !flush;
        if (accept && (phase == PH_LAST)) state_next = SWEEP;
      end
      SWEEP: begin
        tap_valid = 1'b1;
        busy      = 1'b1;
        transfer  = tap_ready && clk_enable && !flush;
        if (transfer && (tap_idx == IDX_LAST)) state_next = IDLE;
      end
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase   <= '0;
      tap_idx <= '0;
    end else if (flush) begin
      phase   <= '0;
      tap_idx <= '0;
    end else if (accept) begin
      if (phase == PH_LAST) begin
        phase   <= '0;
        tap_idx <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end else if (transfer) begin
      tap_idx <= (tap_idx == IDX_LAST) ? '0 : tap_idx + 1'b1;
    end
  end

  // The line only moves on accept, so it is frozen for the whole sweep
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) line[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < TAPS; i++) line[i] <= '0;
    end else if (accept) begin
      line[0] <= filter_in;
      for (int i = 1; i < TAPS; i++) line[i] <= line[i-1];
    end
  end

  assign tap_data    = line[tap_idx];
  assign tap_last    = tap_valid && (tap_idx == IDX_LAST);
  assign frame_start = tap_valid && (tap_idx == '0);

endmodule

// File: doc/fb_tap_sequencer.md
Name: fb_tap_sequencer

Overview:
Parametrised successor to the filterbank delay-line controller. Holds a TAPS-deep signed sample delay line fed through a valid/ready input handshake, and keeps a decimation phase counter. On every DECIM-th accepted sample it streams the whole delay line out serially, one tap per cycle and index 0 first, so serial MAC filters can share a single tap bus. Replaces the gated-clock shift scheme with a true clock enable plus backpressure.

Parameters:
DATA_W, 13, sample width (signed, sfix13_En12 by default)
TAPS, 119, delay-line depth; legal range 2..1024
DECIM, 60, decimation factor: one sweep per DECIM accepted samples; 1 = sweep on every sample
IDX_W, $clog2(TAPS), tap index width (derived)
PH_W, max(1,$clog2(DECIM)), phase width (derived)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
clk_enable  in  1  global enable; when 0, all state holds
flush  in  1  synchronous clear of delay line, phase and FSM
filter_in  in  DATA_W  signed input sample
in_valid  in  1  filter_in is valid
in_ready  out  1  block can accept a sample
tap_data  out  DATA_W  signed tap value, line[tap_idx]
tap_idx  out  IDX_W  current tap index
tap_valid  out  1  tap_data/tap_idx are valid
tap_ready  in  1  consumer takes the tap
tap_last  out  1  tap_valid && tap_idx==TAPS-1
frame_start  out  1  tap_valid && tap_idx==0
phase  out  PH_W  decimation phase, 0..DECIM-1
busy  out  1  FSM is in SWEEP

Behaviour:
- Reset (reset==0, asynchronous): line[*]=0, phase=0, tap_idx=0, FSM=IDLE. Outputs then read in_ready=1, tap_valid=0, tap_data=0, tap_idx=0, tap_last=0, frame_start=0, phase=0, busy=0. Release is synchronous to the next clock edge.
- FSM states: IDLE and SWEEP. in_ready = (state==IDLE). tap_valid = busy = (state==SWEEP).
- Accept = in_valid & in_ready & clk_enable & !flush. On accept:
  - line[i] <= line[i-1] for i = 1..TAPS-1; line[0] <= filter_in; the oldest sample is dropped.
  - If phase==DECIM-1: phase <= 0, FSM -> SWEEP, tap_idx <= 0.
  - Otherwise: phase <= phase+1 and the FSM stays in IDLE.
- Latency: the sample accepted at edge k is tap 0 in the cycle after edge k (frame_start high in that cycle).
- SWEEP:
  - The delay line is frozen. tap_data = line[tap_idx], combinational mux from registered state, stable while stalled.
  - Transfer = tap_valid & tap_ready & clk_enable. On transfer: if tap_idx==TAPS-1, tap_idx <= 0 and FSM -> IDLE; otherwise tap_idx <= tap_idx+1.
  - tap_ready low holds tap_idx and tap_data with no loss.
  - in_valid is ignored (in_ready=0). The upstream must hold the sample.
- clk_enable==0: no state changes (line, phase, tap_idx, FSM). Combinational outputs follow the frozen state.
- flush==1 at an edge: line[*]=0, phase=0, tap_idx=0, FSM=IDLE. This applies regardless of clk_enable. flush has priority over accept and transfer. A sample presented with flush is not accepted.
- DECIM==1: every accepted sample triggers a sweep, and phase stays 0.
- Minimum sweep length is TAPS cycles. Throughput ceiling is one sample per TAPS+1 cycles when DECIM==1, and DECIM samples per DECIM+TAPS cycles otherwise.
- No arithmetic on the data path: values pass through bit-exact, sign preserved.
- Reset asserted mid-SWEEP aborts the sweep immediately. No partial frame resumes after release.

Test Plan:
- Reset: hold reset=0, then release -> in_ready=1, tap_valid=0, phase=0, busy=0. Start one sweep with DECIM=1 -> all tap_data=0.
- Default params: feed samples 1..60 with in_valid held high and tap_ready=1. After samples 1..59: no tap_valid, phase steps 0->59. After 60: sweep gives tap_idx 0..118 on 119 consecutive cycles. Tap 0 = 60, tap 59 = 1, taps 60..118 = 0. tap_last only at idx 118. in_ready returns to 1 the cycle after.
- Backpressure: drop tap_ready for 3 cycles at tap_idx=10 -> tap_idx stays 10 and tap_data is stable. The sweep then resumes at 11 and still totals 119 transfers.
- Input during sweep: drive in_valid=1 with filter_in=-5 throughout the sweep -> no shift until IDLE. -5 is accepted on the first IDLE cycle and phase becomes 1.
- clk_enable=0 for 5 cycles mid-sweep with tap_ready=1 -> tap_idx, phase and line are unchanged. flush mid-sweep -> next cycle IDLE, phase=0; the next sweep reads all zeros except newly accepted samples.
- Assert reset=0 asynchronously at tap_idx=50 (between edges) -> tap_valid drops without a clock edge. After release, a new 60-sample run gives the correct frame.
